// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and condition evaluation for the execute stage
package pipe_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_MUL  = 2'b01,
    MS_DONE = 2'b10
  } mul_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  // ARM condition check against a flags snapshot; 1111 behaves like AL
  function automatic logic cond_holds(input cond_t cond, input flags_t f);
    logic res;
    case (cond)
      COND_EQ: res = f.z;
      COND_NE: res = !f.z;
      COND_CS: res = f.c;
      COND_CC: res = !f.c;
      COND_MI: res = f.n;
      COND_PL: res = !f.n;
      COND_VS: res = f.v;
      COND_VC: res = !f.v;
      COND_HI: res = f.c & !f.z;
      COND_LS: res = !f.c | f.z;
      COND_GE: res = (f.n == f.v);
      COND_LT: res = (f.n != f.v);
      COND_GT: res = !f.z & (f.n == f.v);
      COND_LE: res = f.z | (f.n != f.v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier, one multiplier bit per cycle
module seq_multiplier
  import pipe_pkg::*;
#(
  parameter int MUL_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);

  localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);

  mul_state_t    state, state_nx;
  logic [31:0]   a_sh, b_sh, acc;
  logic [CW-1:0] cnt;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MS_IDLE;
    else        state <= state_nx;
  end

  // next state and status outputs; busy covers the issue cycle so the front end stalls at once
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      MS_IDLE: begin
        busy = start;
        if (start) state_nx = MS_MUL;
      end
      MS_MUL: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = MS_DONE;
      end
      MS_DONE: begin
        done     = 1'b1;
        state_nx = MS_IDLE;
      end
      default: state_nx = MS_IDLE;
    endcase
  end

  // operand capture and shift-add datapath; only the low 32 product bits are kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        MS_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        MS_MUL: begin
          if (b_sh[0]) acc <= acc + a_sh;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: forwarding, ALU, condition check, flags, multiplier, EX/MEM register
module execute_stage
  import pipe_pkg::*;
#(
  parameter int MUL_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrcE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        ALUSrcE,
  input  logic        MulE,
  input  logic [1:0]  ALUControlE,
  input  logic [1:0]  FlagWriteE,
  input  logic [3:0]  CondE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] ExtImmE,
  input  logic [3:0]  WA3E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  input  logic [31:0] ALUOutM,
  output logic        PCSrcM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic        MemWriteM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [3:0]  WA3M,
  output logic [31:0] ALUResultE,
  output logic        BranchTakenE,
  output logic        BusyE
);

  logic [31:0] src_a, fwd_b, src_b, b_eff, alu_result;
  logic [32:0] sum;
  logic        is_sub, cond_ex;
  flags_t      flags_q, alu_flags;
  logic        mul_busy, mul_done;
  logic [31:0] mul_product;

  // forwarding muxes; the store data is the forwarded B before the immediate mux
  always_comb begin
    case (fwd_sel_t'(ForwardAE))
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUOutM;
      default: src_a = RD1E;
    endcase
    case (fwd_sel_t'(ForwardBE))
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALUOutM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b  = ALUSrcE ? ExtImmE : fwd_b;
  assign is_sub = (alu_op_t'(ALUControlE) == ALU_SUB);
  assign b_eff  = is_sub ? ~src_b : src_b;
  assign sum    = {1'b0, src_a} + {1'b0, b_eff} + {32'd0, is_sub};

  // ALU result and the flags it would produce; logical ops clear C and V
  always_comb begin
    alu_result = sum[31:0];
    alu_flags  = '0;
    case (alu_op_t'(ALUControlE))
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
      default: begin
        alu_flags.c = sum[32];
        alu_flags.v = ~(src_a[31] ^ b_eff[31]) & (src_a[31] ^ sum[31]);
      end
    endcase
    alu_flags.n = alu_result[31];
    alu_flags.z = (alu_result == 32'd0);
  end

  assign cond_ex      = cond_holds(cond_t'(CondE), flags_q);
  assign ALUResultE   = alu_result;
  assign BranchTakenE = BranchE & cond_ex;

  // NZCV register; a multiply never touches the flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (cond_ex && !MulE) begin
      if (FlagWriteE[1]) begin
        flags_q.n <= alu_flags.n;
        flags_q.z <= alu_flags.z;
      end
      if (FlagWriteE[0]) begin
        flags_q.c <= alu_flags.c;
        flags_q.v <= alu_flags.v;
      end
    end
  end

  seq_multiplier #(.MUL_ITERS(MUL_ITERS)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (MulE & cond_ex),
    .a       (src_a),
    .b       (fwd_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // reset must drop the stall request immediately, even if a MUL is still presented
  assign BusyE = mul_busy & rst_n;

  // EX/MEM register: bubbles while busy, product on completion, ALU path otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCSrcM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= '0;
    end else if (mul_busy) begin
      PCSrcM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
    end else begin
      PCSrcM     <= PCSrcE & cond_ex;
      RegWriteM  <= RegWriteE & cond_ex;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE & cond_ex;
      ALUResultM <= mul_done ? mul_product : alu_result;
      WriteDataM <= fwd_b;
      WA3M       <= WA3E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

  localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_MI = 4'h4,
                         C_PL = 4'h5, C_VS = 4'h6, C_GE = 4'hA, C_LT = 4'hB,
                         C_AL = 4'hE;

  logic        clk, rst_n;
  logic        PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, MulE;
  logic [1:0]  ALUControlE, FlagWriteE, ForwardAE, ForwardBE;
  logic [3:0]  CondE, WA3E, WA3M;
  logic [31:0] RD1E, RD2E, ExtImmE, ResultW, ALUOutM;
  logic        PCSrcM, RegWriteM, MemtoRegM, MemWriteM, BranchTakenE, BusyE;
  logic [31:0] ALUResultM, WriteDataM, ALUResultE;

  int n_cmp;
  int n_bad;

  execute_stage #(.MUL_ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .MulE(MulE),
    .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE),
    .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .WA3E(WA3E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW), .ALUOutM(ALUOutM),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .WA3M(WA3M),
    .ALUResultE(ALUResultE), .BranchTakenE(BranchTakenE), .BusyE(BusyE)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    PCSrcE = 0; RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; BranchE = 0;
    ALUSrcE = 0; MulE = 0; ALUControlE = 2'b00; FlagWriteE = 2'b00;
    CondE = C_AL; RD1E = 0; RD2E = 0; ExtImmE = 0; WA3E = 0;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 0; ALUOutM = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic probe(input string tag, input logic [3:0] cond, input logic exp);
    @(negedge clk);
    idle();
    BranchE = 1;
    CondE   = cond;
    #1;
    check(tag, BranchTakenE, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    check("rst_alu_m", ALUResultM, 0);
    check("rst_wd_m", WriteDataM, 0);
    check("rst_regw_m", RegWriteM, 0);
    check("rst_busy", BusyE, 0);
    @(negedge clk);
    rst_n = 1;

    // ADD 0xFFFFFFFF + 1 -> 0, NZCV 0110
    RD1E = 32'hFFFF_FFFF; RD2E = 1; FlagWriteE = 2'b11; RegWriteE = 1; WA3E = 4'd3;
    #1 check("add_alu_e", ALUResultE, 0);
    tick();
    check("add_alu_m", ALUResultM, 0);
    check("add_regw_m", RegWriteM, 1);
    check("add_wa3_m", WA3M, 3);
    probe("add_flag_eq", C_EQ, 1);
    probe("add_flag_cs", C_CS, 1);
    probe("add_flag_mi", C_MI, 0);
    probe("add_flag_vs", C_VS, 0);

    // SUB 5 - 7 -> 0xFFFFFFFE, N=1 C=0 V=0, then LT taken and GE not
    @(negedge clk);
    idle();
    RD1E = 5; RD2E = 7; ALUControlE = 2'b01; FlagWriteE = 2'b11;
    #1 check("sub_alu_e", ALUResultE, 32'hFFFF_FFFE);
    tick();
    check("sub_alu_m", ALUResultM, 32'hFFFF_FFFE);
    idle(); CondE = C_LT; RegWriteE = 1;
    tick();
    check("lt_regw_m", RegWriteM, 1);
    CondE = C_GE;
    tick();
    check("ge_regw_m", RegWriteM, 0);

    // forwarding: A from MEM, B from WB, ORR
    idle();
    RD1E = 32'hAAAA; RD2E = 32'h55; ForwardAE = 2'b10; ALUOutM = 32'h10;
    ForwardBE = 2'b01; ResultW = 32'h3; ALUControlE = 2'b11; MemWriteE = 1;
    #1 check("fwd_alu_e", ALUResultE, 32'h13);
    tick();
    check("fwd_alu_m", ALUResultM, 32'h13);
    check("fwd_wd_m", WriteDataM, 32'h3);
    check("fwd_memw_m", MemWriteM, 1);

    // immediate feeds the ALU, register value feeds store data
    idle();
    RD1E = 32'hF0F0; RD2E = 32'h1234; ExtImmE = 32'hFF; ALUSrcE = 1; ALUControlE = 2'b10;
    tick();
    check("imm_alu_m", ALUResultM, 32'hF0);
    check("imm_wd_m", WriteDataM, 32'h1234);

    // MUL 0x00010003 * 5 with immediate present and flag write requested
    idle();
    RD1E = 32'h0001_0003; RD2E = 5; ExtImmE = 32'h99; ALUSrcE = 1; MulE = 1;
    RegWriteE = 1; WA3E = 4'd7; FlagWriteE = 2'b11;
    #1;
    for (int k = 0; k <= 32; k++) begin
      check($sformatf("mul_busy_%0d", k), BusyE, 1);
      tick();
      check($sformatf("mul_bubble_%0d", k), RegWriteM, 0);
    end
    check("mul_busy_done", BusyE, 0);
    tick();
    check("mul_alu_m", ALUResultM, 32'h0005_000F);
    check("mul_regw_m", RegWriteM, 1);
    check("mul_wa3_m", WA3M, 7);
    idle();
    probe("mul_flag_mi", C_MI, 1);
    probe("mul_flag_eq", C_EQ, 0);

    // MUL whose condition fails runs as a gated ALU op
    @(negedge clk);
    idle();
    MulE = 1; CondE = C_EQ; RegWriteE = 1; MemtoRegE = 1; RD1E = 2; RD2E = 3;
    #1 check("mulnc_busy", BusyE, 0);
    tick();
    check("mulnc_regw_m", RegWriteM, 0);
    check("mulnc_mtr_m", MemtoRegM, 1);
    check("mulnc_alu_m", ALUResultM, 5);

    // reset in cycle 10 of a MUL
    idle();
    RD1E = 3; RD2E = 4; MulE = 1; RegWriteE = 1; WA3E = 4'd9;
    #1;
    repeat (10) tick();
    check("rmul_busy_pre", BusyE, 1);
    rst_n = 0;
    #1;
    check("rmul_busy", BusyE, 0);
    check("rmul_alu_m", ALUResultM, 0);
    check("rmul_wd_m", WriteDataM, 0);
    check("rmul_regw_m", RegWriteM, 0);
    idle(); BranchE = 1; CondE = C_PL;
    #1 check("rmul_flag_pl", BranchTakenE, 1);
    CondE = C_LT;
    #1 check("rmul_flag_lt", BranchTakenE, 0);
    @(negedge clk);
    rst_n = 1;
    idle();
    RD1E = 2; RD2E = 6; RegWriteE = 1; WA3E = 4'd4;
    #1 check("post_busy", BusyE, 0);
    tick();
    check("post_alu_m", ALUResultM, 8);
    check("post_regw_m", RegWriteM, 1);
    check("post_wa3_m", WA3M, 4);

    // branch NE with Z=1, then with Z=0
    idle(); FlagWriteE = 2'b11;
    tick();
    idle(); BranchE = 1; PCSrcE = 1; CondE = C_NE; MemtoRegE = 1;
    #1 check("bne_z1_taken", BranchTakenE, 0);
    tick();
    check("bne_z1_pcsrc_m", PCSrcM, 0);
    check("bne_z1_mtr_m", MemtoRegM, 1);
    idle(); RD1E = 1; FlagWriteE = 2'b10;
    tick();
    idle(); BranchE = 1; PCSrcE = 1; CondE = C_NE;
    #1 check("bne_z0_taken", BranchTakenE, 1);
    tick();
    check("bne_z0_pcsrc_m", PCSrcM, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
